uart_crossrx_wr: RTL

Write-side framer for the UART cross-receive buffer. It takes the byte stream from the UART receiver and writes it into the 2048×8 cross-RX dual-port RAM through the RAM's write port. It delimits frames by line-idle timeout, rejects frames that overflow or carry errors, and publishes one committed frame at a time as a descriptor (start address, length) to the read-side logic. It runs entirely in the RAM write-clock domain.

---
 rtl/uart_crossrx_wr.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_crossrx_wr.sv
// Write-side framer for the UART cross-RX ring: writes received bytes into the RAM,
// closes frames on line idle, drops bad/overflowing frames, publishes one descriptor.
module uart_crossrx_wr #(
    parameter int ADDR_W      = 11,
    parameter int IDLE_CYCLES = 1000,
    parameter int MAX_FRAME   = 1024
) (
    input  logic              wrclock,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_vld,
    input  logic              rx_err,
    input  logic [ADDR_W-1:0] rd_free_ptr,
    output logic [7:0]        ram_data,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic              ram_wren,
    output logic              frm_vld,
    output logic [ADDR_W-1:0] frm_start,
    output logic [ADDR_W-1:0] frm_len,
    input  logic              frm_ack,
    output logic [15:0]       drop_cnt
);

    localparam int CNT_W = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] MAX_LEN   = ADDR_W'(MAX_FRAME);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [ADDR_W-1:0]   wr_ptr_r, wr_ptr_nxt_s;
    logic [ADDR_W-1:0]   cur_start_r, cur_start_nxt_s;
    logic [ADDR_W-1:0]   cur_len_r, cur_len_nxt_s;
    logic [CNT_W-1:0]    idle_r, idle_nxt_s;
    logic [ADDR_W-1:0]   used_s;
    logic                full_s;
    logic                timeout_s;
    logic                wren_nxt_s;
    logic [ADDR_W-1:0]   waddr_nxt_s;
    logic [7:0]          wdata_nxt_s;
    logic                fvld_nxt_s;
    logic [ADDR_W-1:0]   fstart_nxt_s;
    logic [ADDR_W-1:0]   flen_nxt_s;
    logic                drop_inc_s;
    logic [15:0]         drop_nxt_s;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Ring occupancy, idle counter next value and the idle-timeout condition.
    // The timeout looks at the counter value being loaded this cycle so that the
    // descriptor appears exactly IDLE_CYCLES after the cycle of the last byte.
    always_comb begin
        used_s = wr_ptr_r - rd_free_ptr;
        full_s = (used_s == {ADDR_W{1'b1}});
        if (rx_vld) begin
            idle_nxt_s = {CNT_W{1'b0}};
        end else if (idle_r == IDLE_LAST) begin
            idle_nxt_s = idle_r;
        end else begin
            idle_nxt_s = idle_r + CNT_W'(1);
        end
        timeout_s = !rx_vld && (idle_nxt_s == IDLE_LAST) && (state_r != S_IDLE);
    end

    // Framing FSM next-state, RAM write and descriptor holding-register logic.
    always_comb begin
        state_nxt_s     = state_r;
        wr_ptr_nxt_s    = wr_ptr_r;
        cur_start_nxt_s = cur_start_r;
        cur_len_nxt_s   = cur_len_r;
        wren_nxt_s      = 1'b0;
        waddr_nxt_s     = ram_wraddress;
        wdata_nxt_s     = ram_data;
        fvld_nxt_s      = frm_vld & ~frm_ack;
        fstart_nxt_s    = frm_start;
        flen_nxt_s      = frm_len;
        drop_inc_s      = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (rx_vld) begin
                    if (!rx_err && !full_s) begin
                        wren_nxt_s      = 1'b1;
                        waddr_nxt_s     = wr_ptr_r;
                        wdata_nxt_s     = rx_data;
                        cur_start_nxt_s = wr_ptr_r;
                        cur_len_nxt_s   = ADDR_W'(1);
                        wr_ptr_nxt_s    = wr_ptr_r + ADDR_W'(1);
                        state_nxt_s     = S_RECV;
                    end else begin
                        state_nxt_s = S_DROP;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RECV: begin
                if (rx_vld) begin
                    if (rx_err || full_s || (cur_len_r == MAX_LEN)) begin
                        wr_ptr_nxt_s = cur_start_r;
                        state_nxt_s  = S_DROP;
                    end else begin
                        wren_nxt_s    = 1'b1;
                        waddr_nxt_s   = wr_ptr_r;
                        wdata_nxt_s   = rx_data;
                        cur_len_nxt_s = cur_len_r + ADDR_W'(1);
                        wr_ptr_nxt_s  = wr_ptr_r + ADDR_W'(1);
                    end
                end else if (timeout_s) begin
                    // Commit only when the holding register is free (or being freed now)
                    if (!frm_vld || frm_ack) begin
                        fvld_nxt_s   = 1'b1;
                        fstart_nxt_s = cur_start_r;
                        flen_nxt_s   = cur_len_r;
                    end else begin
                        wr_ptr_nxt_s = cur_start_r;
                        drop_inc_s   = 1'b1;
                    end
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_RECV;
                end
            end
            S_DROP: begin
                if (timeout_s) begin
                    drop_inc_s  = 1'b1;
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DROP;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase

        if (drop_inc_s) begin
            drop_nxt_s = sat_inc16(drop_cnt);
        end else begin
            drop_nxt_s = drop_cnt;
        end
    end

    // State, pointer and registered-output update with synchronous reset.
    always_ff @(posedge wrclock) begin
        if (rst) begin
            state_r       <= S_IDLE;
            wr_ptr_r      <= {ADDR_W{1'b0}};
            cur_start_r   <= {ADDR_W{1'b0}};
            cur_len_r     <= {ADDR_W{1'b0}};
            idle_r        <= {CNT_W{1'b0}};
            ram_wren      <= 1'b0;
            ram_wraddress <= {ADDR_W{1'b0}};
            ram_data      <= 8'h00;
            frm_vld       <= 1'b0;
            frm_start     <= {ADDR_W{1'b0}};
            frm_len       <= {ADDR_W{1'b0}};
            drop_cnt      <= 16'h0000;
        end else begin
            state_r       <= state_nxt_s;
            wr_ptr_r      <= wr_ptr_nxt_s;
            cur_start_r   <= cur_start_nxt_s;
            cur_len_r     <= cur_len_nxt_s;
            idle_r        <= idle_nxt_s;
            ram_wren      <= wren_nxt_s;
            ram_wraddress <= waddr_nxt_s;
            ram_data      <= wdata_nxt_s;
            frm_vld       <= fvld_nxt_s;
            frm_start     <= fstart_nxt_s;
            frm_len       <= flen_nxt_s;
            drop_cnt      <= drop_nxt_s;
        end
    end

endmodule
